seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed 8-digit seven-segment scan driver inside TopLajiIntelKnightsLanding; produces the board-level seg_n/an_n outputs.
- Consumes a 32-bit display word from the CPU/debug path (register, PC or syscall output, selected by swt).
- Word, decimal-point and blank masks are captured on a load strobe.
- Captured values are applied only at a frame boundary, so a digit row never mixes old and new values.

Parameters:
- CLK_DIV, 100000: clocks per digit slot; must be >= 1. Benches use 4.
- DIGITS, 8: number of scanned digits. Only 8 is supported; an_n and the masks are sized to it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  capture strobe for data/dp_mask/blank_mask
- data  in  32  display word; digit i shows data[4i+3:4i]
- dp_mask  in  8  bit i=1 lights the decimal point of digit i
- blank_mask  in  8  bit i=1 forces digit i dark
- seg_n  out  8  active-low segments: [7]=dp, [6:0]=g,f,e,d,c,b,a
- an_n  out  8  active-low digit enables, at most one low
- frame  out  1  one-cycle pulse when the displayed set is updated at a frame boundary

Behaviour:
- Reset (async, immediate):
  - counters zeroed: div_cnt=0, idx=0
  - shown and pending registers zeroed; pend_v=0
  - outputs: seg_n=8'hFF, an_n=8'hFF, frame=0
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1 and wraps; tick=(div_cnt==CLK_DIV-1).
  - With CLK_DIV=1, tick is asserted every cycle.
- Digit index: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Capture:
  - When load=1, the pending set {data, dp_mask, blank_mask} is written and pend_v <= 1.
  - Repeated loads within one frame: the last load wins.
- Frame boundary (tick && idx==DIGITS-1):
  - If pend_v, shown <= pending, pend_v <= 0, frame <= 1 on the next cycle.
  - If load is also asserted in that cycle, the new load values go directly into shown (bypass) and pend_v stays 0.
  - If neither pend_v nor load, shown is unchanged and frame stays 0.
- Outputs are registered, one cycle after idx/shown:
  - an_n = ~(1<<idx), unless blank_mask_shown[idx]=1, in which case an_n=8'hFF.
  - seg_n[6:0] = hex decode of the shown nibble at idx.
  - seg_n[7] = ~dp_shown[idx].
  - A blanked slot drives seg_n=8'hFF.
- Hex decode, seg_n[6:0] (g..a):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- After reset release:
  - First output cycle shows digit 0 of the zeroed shown set: an_n=8'hFE, seg_n=8'hC0.
  - Nothing new is displayed until the first load plus a frame boundary.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - A pending load is discarded.
- load stuck high: shown tracks data once per frame, with no tearing.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - After each frame update, digits above the highest nonzero nibble are blanked, computed from shown data.
  - Digit 0 is never auto-blanked.
  - The effective blank mask is blank_mask_shown | lzb_mask.
  - A dp bit does not prevent auto-blanking.
- Undefined: only blank_mask blanks digits; all zero nibbles display as "0".

Test Plan:
- Reset, CLK_DIV=4, no load:
  - an_n steps FE, FD, FB, ... 7F, FE, each held 4 cycles.
  - seg_n=C0 throughout.
- load=1 for one cycle with data=32'h89ABCDEF, dp=0, blank=0, mid-frame:
  - Display is unchanged until the frame boundary.
  - frame pulses once.
  - The next frame shows digits 0..7 = 8E,86,A1,C6,83,88,90,80.
- Two loads in one frame (32'h11111111, then 32'h22222222):
  - Only 22222222 is shown: seg_n=A4 on all digits.
- load coincident with the boundary tick (data=32'h0000000F):
  - Applied in that same frame transition (bypass); frame pulses; pend_v=0.
- dp_mask=8'h04, blank_mask=8'h80, data=0:
  - Slot 2 shows seg_n=40.
  - Slot 7 shows an_n=FF, seg_n=FF.
  - All other slots show seg_n=C0.
- Assert rst mid-slot while a load is pending:
  - Outputs are immediately FF/FF.
  - After release, the display restarts at digit 0 with seg_n=C0.
  - The pending value is never shown.
- SEG7_LZB_EN defined, data=32'h00000A05:
  - Slots 3..7 have an_n high.
  - Slots 0..2 show 92, C0, 88.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned update of the shown digit set.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int DIGITS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [31:0]       data,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic [DIGITS-1:0] blank_mask,
  output logic [7:0]        seg_n,
  output logic [DIGITS-1:0] an_n,
  output logic              frame
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_shown_data;
  logic [DIGITS-1:0] r_shown_dp;
  logic [DIGITS-1:0] r_shown_blank;
  logic [31:0]       r_pend_data;
  logic [DIGITS-1:0] r_pend_dp;
  logic [DIGITS-1:0] r_pend_blank;
  logic              r_pend_v;
  logic [7:0]        r_seg_n;
  logic [DIGITS-1:0] r_an_n;
  logic              r_frame;

  logic              w_tick;
  logic              w_boundary;
  logic [3:0]        w_nibble;
  logic [6:0]        w_hex;
  logic [DIGITS-1:0] w_lzb_mask;
  logic [DIGITS-1:0] w_blank_eff;
  logic [7:0]        w_seg_n;
  logic [DIGITS-1:0] w_an_n;

  assign w_tick     = (r_div_cnt == DIV_MAX);
  assign w_boundary = w_tick && (r_idx == IDX_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // A load landing on the boundary itself bypasses the pending stage so it
  // is not held back a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shown_data  <= '0;
      r_shown_dp    <= '0;
      r_shown_blank <= '0;
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
      r_pend_v      <= 1'b0;
      r_frame       <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (w_boundary && load) begin
        r_shown_data  <= data;
        r_shown_dp    <= dp_mask;
        r_shown_blank <= blank_mask;
        r_pend_v      <= 1'b0;
        r_frame       <= 1'b1;
      end else if (w_boundary && r_pend_v) begin
        r_shown_data  <= r_pend_data;
        r_shown_dp    <= r_pend_dp;
        r_shown_blank <= r_pend_blank;
        r_pend_v      <= 1'b0;
        r_frame       <= 1'b1;
      end else if (load) begin
        r_pend_data  <= data;
        r_pend_dp    <= dp_mask;
        r_pend_blank <= blank_mask;
        r_pend_v     <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZB_EN
  // Walk down from the top digit; everything above the first nonzero nibble goes dark.
  always_comb begin
    logic v_nz;
    v_nz       = 1'b0;
    w_lzb_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_nz          = v_nz | (r_shown_data[4*i +: 4] != 4'h0);
      w_lzb_mask[i] = ~v_nz;
    end
  end
`else
  assign w_lzb_mask = '0;
`endif

  assign w_blank_eff = r_shown_blank | w_lzb_mask;
  assign w_nibble    = r_shown_data[4*r_idx +: 4];

  always_comb begin
    w_hex = 7'h7F;
    case (w_nibble)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  always_comb begin
    w_an_n  = '1;
    w_seg_n = 8'hFF;
    if (!w_blank_eff[r_idx]) begin
      w_an_n  = ~(DIGITS'(1) << r_idx);
      w_seg_n = {~r_shown_dp[r_idx], w_hex};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_n <= 8'hFF;
      r_an_n  <= '1;
    end else begin
      r_seg_n <= w_seg_n;
      r_an_n  <= w_an_n;
    end
  end

  assign seg_n = r_seg_n;
  assign an_n  = r_an_n;
  assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (CLK_DIV=4): expected digit slots are queued at stimulus time
// and popped as the scan presents each slot.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic [6:0]  hex_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.CLK_DIV(4), .DIGITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected {an_n, seg_n} for slot i of a displayed set.
  function automatic logic [15:0] exp_slot(input logic [31:0] d, input logic [7:0] dp,
                                           input logic [7:0] bl, input int i);
    logic [7:0] one;
    logic       dark;
    int         hi;
    dark = bl[i];
    hi   = 0;
    for (int k = 0; k < 8; k++) if (d[4*k +: 4] != 4'h0) hi = k;
`ifdef SEG7_LZB_EN
    if (i > hi) dark = 1'b1;
`endif
    one = 8'h01 << i;
    if (dark) return 16'hFFFF;
    return {~one, ~dp[i], hex_tab[d[4*i +: 4]]};
  endfunction

  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                            input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_slot(d, dp, bl, i % 8));
  endtask

  // Called on the negedge just before the first output of digit 0 appears.
  task automatic observe(input string tag, input int n);
    logic [15:0] e;
    for (int s = 0; s < n; s++) begin
      if (s == 0) @(negedge clk);
      else repeat (4) @(negedge clk);
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_slot%0d", tag, s), {16'd0, an_n, seg_n}, {16'd0, e});
      end
      check($sformatf("%s_frame_low%0d", tag, s), {31'd0, frame}, 32'd0);
    end
  endtask

  task automatic wait_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (frame) found = 1'b1;
    end
    check({tag, "_frame_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic no_frame(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (frame) cnt++;
    end
    check({tag, "_no_frame"}, cnt, 32'd0);
  endtask

  task automatic drive_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    load       = 1'b1;
    data       = d;
    dp_mask    = dp;
    blank_mask = bl;
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    data       = 32'h0;
    dp_mask    = 8'h0;
    blank_mask = 8'h0;
    repeat (3) @(negedge clk);
    check("reset_an", {24'd0, an_n}, 32'hFF);
    check("reset_seg", {24'd0, seg_n}, 32'hFF);
    check("reset_frame", {31'd0, frame}, 32'd0);

    // Idle scan: FE..7F then FE again, each slot held 4 cycles.
    rst = 1'b0;
    push_frame(32'h0, 8'h0, 8'h0, 9);
    observe("idle", 9);

    // Mid-frame load; old contents stay until the boundary.
    drive_load(32'h89ABCDEF, 8'h00, 8'h00);
    @(negedge clk);
    load = 1'b0;
    check("hold_old", {16'd0, an_n, seg_n}, {16'd0, exp_slot(32'h0, 8'h0, 8'h0, 0)});
    push_frame(32'h89ABCDEF, 8'h00, 8'h00, 8);
    wait_frame("hexload");
    observe("hexload", 8);

    // Two loads in one frame: the last one wins.
    repeat (4) @(negedge clk);
    drive_load(32'h11111111, 8'h00, 8'h00);
    @(negedge clk);
    drive_load(32'h22222222, 8'h00, 8'h00);
    @(negedge clk);
    load = 1'b0;
    push_frame(32'h22222222, 8'h00, 8'h00, 8);
    wait_frame("lastwins");
    observe("lastwins", 8);

    // Load captured on the boundary edge itself goes straight to the display.
    repeat (2) @(negedge clk);
    drive_load(32'h0000000F, 8'h00, 8'h00);
    push_frame(32'h0000000F, 8'h00, 8'h00, 8);
    @(negedge clk);
    load = 1'b0;
    check("bypass_frame", {31'd0, frame}, 32'd1);
    observe("bypass", 8);
    no_frame("bypass_pend_clear", 40);

    // Decimal point on slot 2, forced blank on slot 7.
    drive_load(32'h0, 8'h04, 8'h80);
    @(negedge clk);
    load = 1'b0;
    push_frame(32'h0, 8'h04, 8'h80, 8);
    wait_frame("dpblank");
    observe("dpblank", 8);

    // Reset mid-slot with a load pending.
    @(negedge clk);
    drive_load(32'h12345678, 8'hFF, 8'h00);
    @(negedge clk);
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midreset_an", {24'd0, an_n}, 32'hFF);
    check("midreset_seg", {24'd0, seg_n}, 32'hFF);
    check("midreset_frame", {31'd0, frame}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_frame(32'h0, 8'h0, 8'h0, 8);
    observe("after_reset", 8);
    no_frame("pending_dropped", 40);

    // Leading-zero case; expectations follow the build's blanking option.
    drive_load(32'h00000A05, 8'h00, 8'h00);
    @(negedge clk);
    load = 1'b0;
    push_frame(32'h00000A05, 8'h00, 8'h00, 8);
    wait_frame("lzb");
    observe("lzb", 8);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
